// File: rtl/sprite_pkg.sv
// sprite_pkg: shared raster constants, colour type and sprite ROM image
package sprite_pkg;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int RASTER_X_W = 10;
  localparam int RASTER_Y_W = 9;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;
  // Sprite image as a pure function of ROM address; every eighth word (addr[2:0]==5) is the key colour
  function automatic logic [23:0] rom_pattern(input logic [15:0] a);
    return (a[2:0] == 3'd5) ? 24'h0AF50B : {a[11:4], a[7:0], ~a[7:0]};
  endfunction
endpackage

// File: rtl/sprite_anim_rom.sv
// sprite_anim_rom: synchronous-read sprite ROM, 24-bit RGB words, 1-cycle latency
module sprite_anim_rom
  import sprite_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [23:0]   data
);
  // Registered read of the sprite image
  always_ff @(posedge clk) data <= rom_pattern(16'(addr));
endmodule

// File: rtl/sprite_anim.sv
// sprite_anim: animated, mirrorable, colour-keyed sprite with frame-latched origin and 2-cycle pipeline
module sprite_anim
  import sprite_pkg::*;
#(
  parameter int          SPRITE_WID = 40,
  parameter int          SPRITE_HGT = 40,
  parameter int          NUM_FRAMES = 4,
  parameter int          FRAME_HOLD = 8,
  parameter int          COLOR_BITS = 4,
  parameter logic [11:0] KEY_COLOR  = 12'h0F0,
  localparam int         FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FRAME_START,
  input  logic [RASTER_X_W-1:0] SPRITE_ORIGIN_OFFSET_X,
  input  logic [RASTER_Y_W-1:0] SPRITE_ORIGIN_OFFSET_Y,
  input  logic                  VISIBLE,
  input  logic                  FLIP_X,
  input  logic                  ANIM_EN,
  input  logic [RASTER_X_W-1:0] RASTER_X,
  input  logic [RASTER_Y_W-1:0] RASTER_Y,
  output logic [COLOR_BITS-1:0] RED,
  output logic [COLOR_BITS-1:0] GRN,
  output logic [COLOR_BITS-1:0] BLU,
  output logic                  VALID,
  output logic [FW-1:0]         FRAME_IDX
);
  localparam int DEPTH = NUM_FRAMES * SPRITE_WID * SPRITE_HGT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  logic [RASTER_X_W-1:0] org_x, lx, lxf;
  logic [RASTER_Y_W-1:0] org_y, ly;
  logic                  vis, flip, in_rect, v1, v2;
  logic [HW-1:0]         hold;
  logic [RASTER_X_W:0]   x_end;
  logic [RASTER_Y_W:0]   y_end;
  logic [AW-1:0]         addr, addr1;
  logic [23:0]           q;
  rgb12_t                px;
  logic                  unused_bits;
  // Shadow registers: sprite placement only changes at vertical blank so a frame never tears
  always_ff @(posedge CLK)
    if (RESET) begin
      org_x <= '0;
      org_y <= '0;
      vis   <= 1'b0;
      flip  <= 1'b0;
    end else if (FRAME_START) begin
      org_x <= SPRITE_ORIGIN_OFFSET_X;
      org_y <= SPRITE_ORIGIN_OFFSET_Y;
      vis   <= VISIBLE;
      flip  <= FLIP_X;
    end
  // Animation: each sprite frame is held for FRAME_HOLD video frames, then wraps through NUM_FRAMES
  always_ff @(posedge CLK)
    if (RESET) begin
      hold      <= '0;
      FRAME_IDX <= '0;
    end else if (FRAME_START && ANIM_EN) begin
      hold      <= (hold == HW'(FRAME_HOLD - 1)) ? '0 : hold + 1'b1;
      FRAME_IDX <= (hold != HW'(FRAME_HOLD - 1)) ? FRAME_IDX
                 : (FRAME_IDX == FW'(NUM_FRAMES - 1)) ? '0 : FRAME_IDX + 1'b1;
    end
  // Stage-1 geometry: widened bounds make the sprite clip at the screen edge instead of wrapping
  always_comb begin
    x_end   = {1'b0, org_x} + (RASTER_X_W + 1)'(SPRITE_WID);
    y_end   = {1'b0, org_y} + (RASTER_Y_W + 1)'(SPRITE_HGT);
    in_rect = (RASTER_X >= org_x) && ({1'b0, RASTER_X} < x_end)
           && (RASTER_Y >= org_y) && ({1'b0, RASTER_Y} < y_end);
    lx      = RASTER_X - org_x;
    ly      = RASTER_Y - org_y;
    lxf     = flip ? RASTER_X_W'(SPRITE_WID - 1) - lx : lx;
    addr    = AW'((32'(FRAME_IDX) * SPRITE_HGT + 32'(ly)) * SPRITE_WID + 32'(lxf));
  end
  // Stage-1 register: ROM address and pixel-coverage flag
  always_ff @(posedge CLK)
    if (RESET) begin
      addr1 <= '0;
      v1    <= 1'b0;
    end else begin
      addr1 <= addr;
      v1    <= in_rect & vis;
    end
  // Stage-2 coverage flag travels alongside the ROM read
  always_ff @(posedge CLK)
    if (RESET) v2 <= 1'b0;
    else v2 <= v1;
  sprite_anim_rom #(.AW(AW)) u_rom (
    .clk  (CLK),
    .addr (addr1),
    .data (q)
  );
  // Stage-2 keying: transparent or uncovered pixels output black with VALID low
  always_comb begin
    px          = '{r: q[23:20], g: q[15:12], b: q[7:4]};
    VALID       = v2 & (px != KEY_COLOR);
    RED         = VALID ? q[23 -: COLOR_BITS] : '0;
    GRN         = VALID ? q[15 -: COLOR_BITS] : '0;
    BLU         = VALID ? q[7 -: COLOR_BITS] : '0;
    unused_bits = ^q;
  end
endmodule
